ftdi_bus_arbiter: RTL
=====================

Name: ftdi_bus_arbiter

Overview:
Half-duplex bus scheduler for the FT60x 245-synchronous FIFO interface, in the usb_clk domain. It sits between the TX/RX AXI4-Stream FIFOs and the FT60x bus state machine. Each cycle it decides which direction owns the shared data/BE bus: write bursts drain the TX FIFO, read bursts fill the RX FIFO. It enforces burst limits, round-robin fairness, bus turnaround gaps and a stall watchdog.

Parameters:
MAX_BURST, 256, maximum beats per grant when the opposite direction is requesting; legal range 1 to 65535.
TURN_CYCLES, 2, idle cycles with both grants low between any release and the next grant; legal range 1 to 15.
TIMEOUT, 1024, cycles a grant may be held with no beat before a forced release; legal range 16 to 65535.
RX_FIRST, 1, tie-break after reset: 1 means RX wins the first simultaneous request, 0 means TX wins.

Ports:
usb_clk  in  1  FT60x source-synchronous clock; the only clock.
rstn_usbclk  in  1  asynchronous, active-low reset.
usb_txe_n  in  1  FT60x TX FIFO full flag (1 = cannot write).
usb_rxf_n  in  1  FT60x RX FIFO empty flag (1 = nothing to read).
tx_valid  in  1  TX FIFO has data (m_axis tvalid, usb_clk side).
tx_beat  in  1  a write beat was accepted on the bus this cycle.
tx_last  in  1  tlast of the beat qualified by tx_beat.
rx_beat  in  1  a read beat was captured this cycle.
rx_afull  in  1  RX FIFO almost full.
grant_tx  out  1  write direction owns the bus.
grant_rx  out  1  read direction owns the bus.
bus_idle  out  1  state is IDLE.
burst_cnt  out  16  beats completed in the current grant.
err_beat  out  1  sticky: a beat arrived without the matching grant.
err_timeout  out  1  sticky: watchdog forced a release.

Behaviour:
- Reset values (async assert, sync deassert edge): state IDLE, grant_tx=0, grant_rx=0, bus_idle=1, burst_cnt=0, err_beat=0, err_timeout=0, last_served = (RX_FIRST ? TX : RX).
- Requests are combinational:
  - tx_req = tx_valid & ~usb_txe_n.
  - rx_req = ~usb_rxf_n & ~rx_afull.
- States: IDLE, TX, RX, TURN. All outputs are registered.
- IDLE:
  - Only tx_req → TX.
  - Only rx_req → RX.
  - Both → the direction opposite to last_served.
  - Neither → stay in IDLE.
  - The grant is high in the cycle after the request is seen (1-cycle latency).
- On entering TX or RX: burst_cnt=0, last_served updated, watchdog cleared.
- TX: each tx_beat increments burst_cnt (saturates at 65535) and clears the watchdog. Release (→ TURN) on the first of:
  - tx_beat & tx_last;
  - tx_beat and burst_cnt+1 >= MAX_BURST while rx_req = 1;
  - usb_txe_n = 1;
  - watchdog reaches TIMEOUT.
- RX: same structure, using rx_beat. Release on the first of:
  - usb_rxf_n = 1;
  - rx_afull = 1;
  - rx_beat and burst_cnt+1 >= MAX_BURST while tx_req = 1;
  - watchdog reaches TIMEOUT.
- Burst limit with the opposite side idle: burst_cnt wraps to 0 at MAX_BURST and the grant is kept.
- Release timing: the grant drops in the cycle after the terminating condition. A beat in the terminating cycle is still counted.
- TURN: both grants low for exactly TURN_CYCLES cycles, then → IDLE. Requests seen during TURN are ignored. The minimum gap between grants is TURN_CYCLES+1 cycles.
- Simultaneous events:
  - tx_last together with the burst limit → a single release.
  - The watchdog and a beat in the same cycle → the beat wins and the watchdog clears.
- err_beat is set on (tx_beat & ~grant_tx) | (rx_beat & ~grant_rx). err_timeout is set on a watchdog release. Both clear only on reset.
- Reset mid-burst: grants drop asynchronously, there is no TURN, and the controller returns to IDLE.
- grant_tx & grant_rx is never 1 (assertion).

Decomposition:
- Shared package ftdi_pkg holds:
  - state encoding (IDLE=2'd0, TX=2'd1, RX=2'd2, TURN=2'd3);
  - direction constants DIR_TX / DIR_RX;
  - the 16-bit counter width constant.
- One natural sub-module: ftdi_arb_watchdog, a loadable 16-bit down-counter with clear and an expiry pulse.
- Everything else stays in the top FSM.

Test Plan:
- tx_valid=1, usb_txe_n=0, rxf_n=1; 5 beats with tx_last on beat 5 → grant_tx rises 1 cycle after the request, burst_cnt reaches 5, grant_tx drops next cycle, 2 idle cycles, then bus_idle=1.
- Both requests held after reset with RX_FIRST=1 and MAX_BURST=4; continuous beats → grants alternate RX, TX, RX, TX, each 4 beats, with a 3-cycle gap between grants.
- RX only, MAX_BURST=4, 10 beats → grant_rx is held throughout; burst_cnt reads 0,1,2,3,0,1,...
- RX granted, rx_afull asserted mid-burst → grant_rx drops 1 cycle later; no re-grant until rx_afull=0 and TURN has elapsed.
- TX granted with no tx_beat for TIMEOUT=16 cycles → release at cycle 16 and err_timeout=1 (sticky).
- Pulse rx_beat while in IDLE → err_beat=1; assert rstn_usbclk=0 mid-TX → grant_tx=0 immediately and all outputs return to reset values.

Source files
------------

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT60x half-duplex bus arbiter.
package ftdi_pkg;

    localparam int unsigned CntWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StTx   = 2'd1,
        StRx   = 2'd2,
        StTurn = 2'd3
    } arb_state_e;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == '1) ? v : v + {{(CntWidth-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ftdi_bus_arbiter_if.sv
// Request/beat inputs and grant/status outputs of the FT60x bus arbiter.
interface ftdi_bus_arbiter_if;
    import ftdi_pkg::*;

    logic                usb_txe_n;
    logic                usb_rxf_n;
    logic                tx_valid;
    logic                tx_beat;
    logic                tx_last;
    logic                rx_beat;
    logic                rx_afull;
    logic                grant_tx;
    logic                grant_rx;
    logic                bus_idle;
    logic [CntWidth-1:0] burst_cnt;
    logic                err_beat;
    logic                err_timeout;

    modport master (
        input  usb_txe_n, usb_rxf_n, tx_valid, tx_beat, tx_last, rx_beat, rx_afull,
        output grant_tx, grant_rx, bus_idle, burst_cnt, err_beat, err_timeout
    );

    modport slave (
        output usb_txe_n, usb_rxf_n, tx_valid, tx_beat, tx_last, rx_beat, rx_afull,
        input  grant_tx, grant_rx, bus_idle, burst_cnt, err_beat, err_timeout
    );

endinterface

// File: rtl/ftdi_arb_watchdog.sv
// Loadable down-counter that pulses expired_o on the last counted cycle of a stalled grant.
module ftdi_arb_watchdog
    import ftdi_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    input  logic                clr_i,
    input  logic                count_i,
    output logic                expired_o
);

    localparam logic [CntWidth-1:0] One = CntWidth'(1);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (count_i && cnt_q != '0) begin
            cnt_d = cnt_q - One;
        end
    end

    // A load (beat) in the same cycle suppresses expiry.
    assign expired_o = count_i & ~load_i & ~clr_i & (cnt_q == One);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ftdi_bus_arbiter.sv
// Half-duplex FT60x bus scheduler: picks TX or RX ownership with burst limits,
// round-robin tie-break, turnaround gaps and a stall watchdog.
module ftdi_bus_arbiter
    import ftdi_pkg::*;
#(
    parameter int unsigned MAX_BURST   = 256,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 1024,
    parameter bit          RX_FIRST    = 1'b1
) (
    input logic                usb_clk,
    input logic                rstn_usbclk,
    ftdi_bus_arbiter_if.master bus
);

    localparam logic [CntWidth:0]   MaxBurst = (CntWidth+1)'(MAX_BURST);
    localparam logic [CntWidth-1:0] WdLoad   = CntWidth'(TIMEOUT);
    localparam logic [3:0]          TurnLoad = 4'(TURN_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [CntWidth-1:0] burst_cnt_q, burst_cnt_d;
    logic [3:0]          turn_cnt_q, turn_cnt_d;
    logic                last_served_q, last_served_d;
    logic                err_beat_q, err_beat_d;
    logic                err_timeout_q, err_timeout_d;

    logic                tx_req, rx_req;
    logic                in_tx, in_rx, in_grant;
    logic                beat, opp_req, limit;
    logic [CntWidth:0]   cnt_inc;
    logic                wd_load, wd_clr, wd_expired;

    assign tx_req   = bus.tx_valid & ~bus.usb_txe_n;
    assign rx_req   = ~bus.usb_rxf_n & ~bus.rx_afull;
    assign in_tx    = (state_q == StTx);
    assign in_rx    = (state_q == StRx);
    assign in_grant = in_tx | in_rx;
    assign beat     = (in_tx & bus.tx_beat) | (in_rx & bus.rx_beat);
    assign opp_req  = in_tx ? rx_req : tx_req;
    assign cnt_inc  = {1'b0, burst_cnt_q} + {{CntWidth{1'b0}}, 1'b1};
    assign limit    = beat & (cnt_inc >= MaxBurst);

    // Reload on every grant entry and every beat; idle otherwise.
    assign wd_load = beat | ((state_q == StIdle) & (tx_req | rx_req));
    assign wd_clr  = ~in_grant & ~wd_load;

    ftdi_arb_watchdog u_watchdog (
        .clk_i      (usb_clk),
        .rst_ni     (rstn_usbclk),
        .load_i     (wd_load),
        .load_val_i (WdLoad),
        .clr_i      (wd_clr),
        .count_i    (in_grant),
        .expired_o  (wd_expired)
    );

    always_comb begin
        logic rel;
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        turn_cnt_d    = turn_cnt_q;
        last_served_d = last_served_q;
        rel           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_req && (!rx_req || last_served_q == DIR_RX)) begin
                    state_d       = StTx;
                    last_served_d = DIR_TX;
                    burst_cnt_d   = '0;
                end else if (rx_req) begin
                    state_d       = StRx;
                    last_served_d = DIR_RX;
                    burst_cnt_d   = '0;
                end
            end
            StTx, StRx: begin
                if (in_tx) begin
                    rel = (bus.tx_beat & bus.tx_last) | bus.usb_txe_n;
                end else begin
                    rel = bus.usb_rxf_n | bus.rx_afull;
                end
                rel = rel | (limit & opp_req) | wd_expired;
                // Wrap at the limit only while the grant is kept.
                if (beat) begin
                    burst_cnt_d = (limit && !rel) ? '0 : sat_inc(burst_cnt_q);
                end
                if (rel) begin
                    state_d    = StTurn;
                    turn_cnt_d = TurnLoad;
                end
            end
            StTurn: begin
                if (turn_cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
        endcase

        err_beat_d    = err_beat_q | (bus.tx_beat & ~in_tx) | (bus.rx_beat & ~in_rx);
        err_timeout_d = err_timeout_q | wd_expired;
    end

    always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
        if (!rstn_usbclk) begin
            state_q       <= StIdle;
            burst_cnt_q   <= '0;
            turn_cnt_q    <= '0;
            last_served_q <= RX_FIRST ? DIR_TX : DIR_RX;
            err_beat_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            last_served_q <= last_served_d;
            err_beat_q    <= err_beat_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.grant_tx    = in_tx;
    assign bus.grant_rx    = in_rx;
    assign bus.bus_idle    = (state_q == StIdle);
    assign bus.burst_cnt   = burst_cnt_q;
    assign bus.err_beat    = err_beat_q;
    assign bus.err_timeout = err_timeout_q;

    grant_exclusive_a: assert property (@(posedge usb_clk) disable iff (!rstn_usbclk)
        !(bus.grant_tx && bus.grant_rx));

endmodule
